// File: rtl/mod_seq_pkg.sv
// mod_seq_pkg: shared types and helpers for the sequential remainder controller.
//   state_t   : controller FSM states (IDLE, CALC, DONE)
//   cnt_width : width of the step counter needed to hold N-1
package mod_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter runs from n-1 down to 0, so $clog2(n) bits always suffice.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_step.sv
// mod_step: one combinational restoring shift-subtract division step.
//   r      [N:0]   partial remainder in
//   q      [N-1:0] dividend/quotient shift register in
//   d      [N-1:0] divisor
//   r_next [N:0]   partial remainder out
//   q_next [N-1:0] shifted quotient with new bit in LSB
module mod_step #(
  parameter int N = 7
) (
  input  logic [N:0]   r,
  input  logic [N-1:0] q,
  input  logic [N-1:0] d,
  output logic [N:0]   r_next,
  output logic [N-1:0] q_next
);

  logic [N:0]   t;
  logic [N:0]   d_ext;
  logic [N-1:0] qs;

  always_comb begin
    // r[N] is always 0 between steps (remainder stays below d); it is
    // folded into the MSB so the full input word participates.
    t      = {r[N-1:0], q[N-1]} | {r[N], {N{1'b0}}};
    d_ext  = {1'b0, d};
    qs     = {q[N-2:0], 1'b0};
    r_next = t;
    q_next = qs;
    if (t >= d_ext) begin
      r_next = t - d_ext;
      q_next = qs | N'(1);
    end
  end

endmodule

// File: rtl/mod_seq_ctrl.sv
// mod_seq_ctrl: multicycle unsigned divider returning quotient and remainder.
// One restoring step per clock; N CALC cycles then a one-cycle DONE.
//   clk, rst_n   : clock (rising edge), synchronous active-low reset
//   start        : request, sampled only in IDLE
//   dividend     : unsigned dividend, sampled with start
//   divider      : unsigned divisor, sampled with start
//   busy         : high while in CALC or DONE
//   done         : single-cycle pulse when results are valid
//   quotient     : registered quotient
//   remainder    : registered remainder
//   div_by_zero  : set with done when divider was 0
module mod_seq_ctrl
  import mod_seq_pkg::*;
#(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divider,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(N);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  d_q, d_d;
  logic [N-1:0]  q_q, q_d;
  logic [N:0]    r_q, r_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dz_q, dz_d;

  logic [N:0]    step_r;
  logic [N-1:0]  step_q;

  mod_step #(.N(N)) u_step (
    .r      (r_q),
    .q      (q_q),
    .d      (d_q),
    .r_next (step_r),
    .q_next (step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divider != '0) begin
            state_d = CALC;
            d_d     = divider;
            q_d     = dividend;
            r_d     = '0;
            cnt_d   = CW'(N - 1);
          end else begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
          end
        end
      end
      CALC: begin
        r_d = step_r;
        q_d = step_q;
        // The final step's result is captured straight from the step logic
        // so the result lands in the same edge that enters DONE.
        if (cnt_q == '0) begin
          quot_d  = step_q;
          rem_d   = step_r[N-1:0];
          dz_d    = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_mod_seq_ctrl.sv
module tb_mod_seq_ctrl;

  localparam int N = 7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divider;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  // Results currently expected on the output registers (hold check).
  int prev_q = 0;
  int prev_r = 0;
  int prev_dz = 0;

  always #5 clk = ~clk;

  mod_seq_ctrl #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divider     (divider),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    int a;
    int b;
    int eq;
    int er;
    int edz;
    int elat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and check latency, results and hold behaviour.
  task automatic run_op(input int a, input int b, input int eq, input int er,
                        input int edz, input int elat);
    int lat;
    start    = 1'b1;
    dividend = N'(a);
    divider  = N'(b);
    tick();
    start    = 1'b0;
    dividend = '0;
    divider  = '0;
    lat = 1;
    chk("busy_after_start", int'(busy), 1);
    while (!done && lat < 20) begin
      chk("hold_q", int'(quotient), prev_q);
      chk("hold_r", int'(remainder), prev_r);
      chk("hold_dz", int'(div_by_zero), prev_dz);
      tick();
      lat++;
    end
    chk("done_seen", int'(done), 1);
    chk("latency", lat, elat);
    chk("quotient", int'(quotient), eq);
    chk("remainder", int'(remainder), er);
    chk("div_by_zero", int'(div_by_zero), edz);
    prev_q  = eq;
    prev_r  = er;
    prev_dz = edz;
    tick();
    chk("done_pulse_end", int'(done), 0);
    chk("busy_end", int'(busy), 0);
  endtask

  vec_t vecs[$];

  initial begin
    int ndone;

    vecs.push_back('{11, 5, 2, 1, 0, 8});
    vecs.push_back('{12, 5, 2, 2, 0, 8});
    vecs.push_back('{15, 3, 5, 0, 0, 8});
    vecs.push_back('{100, 55, 1, 45, 0, 8});
    vecs.push_back('{127, 1, 127, 0, 0, 8});
    vecs.push_back('{5, 9, 0, 5, 0, 8});
    vecs.push_back('{0, 7, 0, 0, 0, 8});
    vecs.push_back('{127, 127, 1, 0, 0, 8});
    vecs.push_back('{9, 0, 127, 9, 1, 1});
    vecs.push_back('{12, 5, 2, 2, 0, 8});

    // Reset with start asserted: reset wins.
    rst_n    = 1'b0;
    start    = 1'b1;
    dividend = N'(11);
    divider  = N'(5);
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_q", int'(quotient), 0);
    chk("rst_r", int'(remainder), 0);
    chk("rst_dz", int'(div_by_zero), 0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", int'(busy), 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      run_op(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].edz, vecs[i].elat);
    end

    // Overlap: second request while busy must be ignored.
    @(negedge clk);
    start    = 1'b1;
    dividend = N'(11);
    divider  = N'(5);
    tick();
    start = 1'b0;
    ndone = 0;
    tick();
    tick();
    start    = 1'b1;
    dividend = N'(100);
    divider  = N'(55);
    tick();
    start    = 1'b0;
    dividend = '0;
    divider  = '0;
    for (int c = 0; c < 25; c++) begin
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          chk("ovl_q", int'(quotient), 2);
          chk("ovl_r", int'(remainder), 1);
        end
      end
      tick();
    end
    chk("ovl_done_count", ndone, 1);
    prev_q  = 2;
    prev_r  = 1;
    prev_dz = 0;

    // Abort mid-CALC via reset.
    @(negedge clk);
    start    = 1'b1;
    dividend = N'(100);
    divider  = N'(55);
    tick();
    start = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_q", int'(quotient), 0);
    chk("abort_r", int'(remainder), 0);
    chk("abort_dz", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_no_done", ndone, 0);
    prev_q  = 0;
    prev_r  = 0;
    prev_dz = 0;
    @(negedge clk);
    run_op(15, 3, 5, 0, 0, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
